// File: rtl/dso_decimator_mc.sv
// Multi-channel DSO decimator: reduces every deci_rate accepted ADC samples
// to one sample per channel using last / max / min / average reduction.
module dso_decimator_mc #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CH_NUM = 2,
  parameter int unsigned RATE_W = 10
) (
  input  logic                       ad_clk,
  input  logic                       rstn,
  input  logic [RATE_W-1:0]          deci_rate,
  input  logic [1:0]                 deci_mode,
  input  logic                       restart,
  input  logic                       ad_valid,
  input  logic [CH_NUM*DATA_W-1:0]   ad_data,
  output logic                       deci_valid,
  output logic [CH_NUM*DATA_W-1:0]   deci_data
);

  // Accumulator is wide enough to sum a full-length window without overflow.
  localparam int unsigned ACC_W = DATA_W + RATE_W;
  localparam int unsigned SH_W  = $clog2(RATE_W + 1);
  localparam int unsigned BUS_W = CH_NUM * DATA_W;

  typedef enum logic [1:0] {
    MODE_SAMPLE = 2'd0,
    MODE_MAX    = 2'd1,
    MODE_MIN    = 2'd2,
    MODE_AVG    = 2'd3
  } mode_e;

  // Index of the highest set bit; rate is never zero when this is used.
  function automatic logic [SH_W-1:0] floor_log2(input logic [RATE_W-1:0] r);
    floor_log2 = '0;
    for (int i = 0; i < int'(RATE_W); i++) begin
      if (r[i]) floor_log2 = SH_W'(i);
    end
  endfunction

  logic [RATE_W-1:0] cnt_q;
  logic [RATE_W-1:0] rate_q;
  mode_e             mode_q;

  logic              first_c;
  logic              close_c;
  logic [RATE_W-1:0] rate_c;
  mode_e             mode_c;
  logic [RATE_W-1:0] cnt_inc_c;
  logic [SH_W-1:0]   sh_c;
  logic [BUS_W-1:0]  res_all_c;

  // Window control: effective rate/mode (freshly latched on a window start),
  // next count and window-close detection.
  always_comb begin
    first_c = ad_valid && (restart || (cnt_q == '0));
    rate_c  = rate_q;
    mode_c  = mode_q;
    if (first_c) begin
      rate_c = (deci_rate == '0) ? RATE_W'(1) : deci_rate;
      mode_c = mode_e'(deci_mode);
    end
    cnt_inc_c = first_c ? RATE_W'(1) : (cnt_q + RATE_W'(1));
    close_c   = ad_valid && (cnt_inc_c == rate_c);
    sh_c      = floor_log2(rate_c);
  end

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    logic [DATA_W-1:0] samp_c;
    logic [DATA_W-1:0] cur_c;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  acc_d;
    logic [ACC_W-1:0]  avg_c;
    logic [DATA_W-1:0] res_c;

    // Per-channel accumulator update and reduced result for a closing window.
    always_comb begin
      samp_c = ad_data[k*DATA_W +: DATA_W];
      cur_c  = acc_q[DATA_W-1:0];
      acc_d  = acc_q;
      if (ad_valid) begin
        if (first_c) begin
          acc_d = ACC_W'(samp_c);
        end else begin
          case (mode_c)
            MODE_SAMPLE: acc_d = ACC_W'(samp_c);
            MODE_MAX:    acc_d = (samp_c > cur_c) ? ACC_W'(samp_c) : acc_q;
            MODE_MIN:    acc_d = (samp_c < cur_c) ? ACC_W'(samp_c) : acc_q;
            default:     acc_d = acc_q + ACC_W'(samp_c);
          endcase
        end
      end
      avg_c = acc_d >> sh_c;
      res_c = acc_d[DATA_W-1:0];
      if (mode_c == MODE_AVG) begin
        // Non power-of-two rates divide by less than the count; clamp.
        res_c = (|avg_c[ACC_W-1:DATA_W]) ? {DATA_W{1'b1}} : avg_c[DATA_W-1:0];
      end
    end

    // Accumulator register.
    always_ff @(posedge ad_clk) begin
      if (!rstn) acc_q <= '0;
      else       acc_q <= acc_d;
    end

    assign res_all_c[k*DATA_W +: DATA_W] = res_c;
  end

  // Shared counter, latched configuration and registered outputs.
  always_ff @(posedge ad_clk) begin
    if (!rstn) begin
      cnt_q      <= '0;
      rate_q     <= RATE_W'(1);
      mode_q     <= MODE_SAMPLE;
      deci_valid <= 1'b0;
      deci_data  <= '0;
    end else begin
      deci_valid <= close_c;
      if (close_c) deci_data <= res_all_c;
      if (ad_valid) begin
        rate_q <= rate_c;
        mode_q <= mode_c;
        cnt_q  <= close_c ? '0 : cnt_inc_c;
      end else if (restart) begin
        cnt_q <= '0;
      end
    end
  end

endmodule
